// File: rtl/matrix_pkg.sv
// Shared constants, opcodes, state encoding and element helpers for the
// matrix ALU. The element width, matrix order and opcodes live here so that
// the top level and the dot-product datapath stay consistent.
package matrix_pkg;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = DIM * DIM * ELEM_W;  // 200

  localparam logic [2:0] OP_ADD       = 3'd0;
  localparam logic [2:0] OP_SUB       = 3'd1;
  localparam logic [2:0] OP_MUL       = 3'd2;
  localparam logic [2:0] OP_SCALE     = 3'd3;
  localparam logic [2:0] OP_TRANSPOSE = 3'd4;

  // Last row-major index of a MUL sweep (r*5+c for r=c=4).
  localparam logic [4:0] MUL_LAST = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       ovf;
    logic [7:0] val;
  } sat_t;

  // Clamp any signed intermediate (sign-extended to 32 bits) into int8.
  function automatic sat_t saturate8(input logic signed [31:0] v);
    sat_t s;
    if (v > 32'sd127) begin
      s.ovf = 1'b1;
      s.val = 8'h7f;
    end else if (v < -32'sd128) begin
      s.ovf = 1'b1;
      s.val = 8'h80;
    end else begin
      s.ovf = 1'b0;
      s.val = v[7:0];
    end
    return s;
  endfunction

  // Bit offset of element (r,c) inside a packed matrix.
  function automatic int elem_lsb(input int r, input int c);
    return (r * DIM + c) * ELEM_W;
  endfunction

endpackage

// File: rtl/matrix_alu_if.sv
// Operation request / result bus of the matrix ALU.
// Handshake: the requester raises start for one cycle while the DUT is idle
// (busy low); operands, op and scalar are captured on that edge and may change
// afterwards. done pulses for exactly one cycle when matrix_C, overflow and err
// are final; busy covers the whole operation and start is ignored while busy.
interface matrix_alu_if;
  import matrix_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [7:0]       scalar;
  logic [MAT_W-1:0] matrix_A;
  logic [MAT_W-1:0] matrix_B;
  logic [MAT_W-1:0] matrix_C;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             err;

  modport master (
    output start, op, scalar, matrix_A, matrix_B,
    input  matrix_C, busy, done, overflow, err
  );

  modport slave (
    input  start, op, scalar, matrix_A, matrix_B,
    output matrix_C, busy, done, overflow, err
  );

endinterface

// File: rtl/matrix_dot5.sv
// Combinational dot product of one A row and one B column: five signed
// 8x8 products (16 bit) summed into a 19-bit accumulator, which cannot wrap.
module matrix_dot5
  import matrix_pkg::*;
(
  input  logic [DIM*ELEM_W-1:0] a_row,
  input  logic [DIM*ELEM_W-1:0] b_col,
  output logic signed [18:0]    sum
);

  logic signed [7:0]  pa;
  logic signed [7:0]  pb;
  logic signed [15:0] prod;

  // Multiply-accumulate across the five element pairs.
  always_comb begin
    sum  = '0;
    pa   = '0;
    pb   = '0;
    prod = '0;
    for (int k = 0; k < DIM; k++) begin
      pa   = $signed(a_row[k*ELEM_W +: ELEM_W]);
      pb   = $signed(b_col[k*ELEM_W +: ELEM_W]);
      prod = 16'(pa) * 16'(pb);
      sum  = sum + 19'(prod);
    end
  end

endmodule

// File: rtl/matrix_alu.sv
// Sequential 5x5 int8 matrix ALU: add, subtract, multiply, scale, transpose.
// Elementwise ops finish in one EXEC cycle; MUL sweeps 25 elements, one per
// cycle, into a private buffer so matrix_C only ever shows complete results.
module matrix_alu
  import matrix_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  matrix_alu_if.slave  bus,
  output state_e       state_dbg
);

  typedef struct packed {
    logic             ovf;
    logic [MAT_W-1:0] m;
  } ew_t;

  // Elementwise ops and transpose over the whole matrix in one shot.
  function automatic ew_t elementwise(input logic [2:0] op,
                                      input logic [MAT_W-1:0] a,
                                      input logic [MAT_W-1:0] b,
                                      input logic [7:0] sc);
    ew_t               res;
    sat_t              s;
    logic signed [7:0]  ea;
    logic signed [7:0]  eb;
    logic signed [7:0]  et;
    logic signed [8:0]  s9;
    logic signed [15:0] p16;
    logic signed [31:0] w;
    res.ovf = 1'b0;
    res.m   = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        ea  = $signed(a[elem_lsb(r, c) +: ELEM_W]);
        eb  = $signed(b[elem_lsb(r, c) +: ELEM_W]);
        et  = $signed(a[elem_lsb(c, r) +: ELEM_W]);
        s9  = '0;
        p16 = '0;
        w   = '0;
        case (op)
          OP_ADD: begin
            s9 = 9'(ea) + 9'(eb);
            w  = 32'(s9);
          end
          OP_SUB: begin
            s9 = 9'(ea) - 9'(eb);
            w  = 32'(s9);
          end
          OP_SCALE: begin
            p16 = 16'(ea) * 16'($signed(sc));
            w   = 32'(p16);
          end
          OP_TRANSPOSE: w = 32'(et);
          default:      w = '0;
        endcase
        s = saturate8(w);
        res.m[elem_lsb(r, c) +: ELEM_W] = s.val;
        res.ovf = res.ovf | s.ovf;
      end
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       scalar_q, scalar_d;
  logic [MAT_W-1:0] a_q, a_d;
  logic [MAT_W-1:0] b_q, b_d;
  logic [MAT_W-1:0] res_q, res_d;
  logic [MAT_W-1:0] c_q, c_d;
  logic [4:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [4:0]            mul_r;
  logic [4:0]            mul_c;
  logic [DIM*ELEM_W-1:0] a_row;
  logic [DIM*ELEM_W-1:0] b_col;
  logic signed [18:0]    dot_sum;
  sat_t                  mul_sat;
  ew_t                   ew_res;

  // Select the A row and B column addressed by the current MUL index.
  always_comb begin
    mul_r = idx_q / 5'(DIM);
    mul_c = idx_q % 5'(DIM);
    a_row = '0;
    b_col = '0;
    for (int k = 0; k < DIM; k++) begin
      a_row[k*ELEM_W +: ELEM_W] = a_q[elem_lsb(int'(mul_r), k) +: ELEM_W];
      b_col[k*ELEM_W +: ELEM_W] = b_q[elem_lsb(k, int'(mul_c)) +: ELEM_W];
    end
  end

  matrix_dot5 u_dot (
    .a_row (a_row),
    .b_col (b_col),
    .sum   (dot_sum)
  );

  // Saturate the current dot product and the full elementwise result.
  always_comb begin
    mul_sat = saturate8(32'(dot_sum));
    ew_res  = elementwise(op_q, a_q, b_q, scalar_q);
  end

  // Next-state and next-output logic of the IDLE/EXEC/DONE controller.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    scalar_d = scalar_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    c_d      = c_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          a_d      = bus.matrix_A;
          b_d      = bus.matrix_B;
          op_d     = bus.op;
          scalar_d = bus.scalar;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_MUL) begin
          res_d[int'(idx_q)*ELEM_W +: ELEM_W] = mul_sat.val;
          ovf_d = ovf_q | mul_sat.ovf;
          if (idx_q == MUL_LAST) begin
            c_d     = res_d;
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else if (op_q > OP_TRANSPOSE) begin
          err_d   = 1'b1;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          res_d   = ew_res.m;
          c_d     = ew_res.m;
          ovf_d   = ew_res.ovf;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      scalar_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      c_q      <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      scalar_q <= scalar_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign bus.matrix_C = c_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.err      = err_q;
  assign state_dbg    = state_q;

endmodule
